vend_dispenser: RTL and testbench

//  Dispense-side responder for the vending FSM: takes the dispense request (d) and

---
 rtl/vend_dispenser_if.sv | 27 ++
 rtl/vend_dispenser.sv | 212 +++++++++++++++++++++
 tb/tb_vend_dispenser.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vend_dispenser_if.sv
// Dispense handshake bundle between the vending FSM (master) and the
// dispenser (slave). The drop sensor and refill pulse travel with it so the
// dispenser sees its whole environment through one port.
interface vend_dispenser_if #(
    parameter int N_SLOTS = 8
);
    logic               req;
    logic [2:0]         prod;
    logic               drop_sns;
    logic               refill;
    logic [N_SLOTS-1:0] motor;
    logic               busy;
    logic               ack;
    logic               nack;
    logic               fault;
    logic [N_SLOTS-1:0] empty;

    modport master (
        output req, prod, drop_sns, refill,
        input  motor, busy, ack, nack, fault, empty
    );

    modport slave (
        input  req, prod, drop_sns, refill,
        output motor, busy, ack, nack, fault, empty
    );
endinterface

// File: rtl/vend_dispenser.sv
// Dispense-side responder: runs one slot motor for a fixed time, confirms the
// drop on the sensor, tracks per-slot stock and answers ack / nack / fault
// over a four-phase level handshake. Every output is a flop loaded from the
// next-state decode, so outputs follow registered state with no input path.
module vend_dispenser #(
    parameter int N_SLOTS      = 8,
    parameter int RUN_CYCLES   = 16,
    parameter int DROP_TIMEOUT = 64,
    parameter int STOCK_W      = 4,
    parameter int STOCK_INIT   = 5
) (
    input  logic             clk,
    input  logic             rst,
    vend_dispenser_if.slave  bus
);

    localparam int CNT_MAX = (RUN_CYCLES > DROP_TIMEOUT) ? RUN_CYCLES : DROP_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DROP_LAST  = CNT_W'(DROP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [STOCK_W-1:0] STOCK_LOAD = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0] STOCK_ZERO = {STOCK_W{1'b0}};
    localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RUN      = 3'd1;
    localparam logic [2:0] S_DROP     = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_NACK     = 3'd4;
    localparam logic [2:0] S_WAIT_REL = 3'd5;
    localparam logic [2:0] S_FAULT    = 3'd6;

    // Architectural state
    logic [2:0]         state_r;
    logic [2:0]         slot_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               drop_seen_r;
    logic [STOCK_W-1:0] stock [N_SLOTS];

    // Registered outputs
    logic [N_SLOTS-1:0] motor_r;
    logic               busy_r;
    logic               ack_r;
    logic               nack_r;
    logic               fault_r;
    logic [N_SLOTS-1:0] empty_r;

    // Next-state values
    logic [2:0]         state_nxt_s;
    logic [2:0]         slot_nxt_s;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               drop_seen_nxt_s;
    logic [STOCK_W-1:0] stock_nxt_s [N_SLOTS];
    logic               prod_valid_s;
    logic               prod_stocked_s;
    logic [N_SLOTS-1:0] motor_nxt_s;
    logic [N_SLOTS-1:0] empty_nxt_s;

    // Look up the requested code: in range, and does its slot still hold stock
    always_comb begin
        prod_valid_s   = 1'b0;
        prod_stocked_s = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            prod_valid_s   = prod_valid_s | (bus.prod == 3'(i));
            prod_stocked_s = prod_stocked_s | ((bus.prod == 3'(i)) && (stock[i] != STOCK_ZERO));
        end
    end

    // Dispense sequencing and stock bookkeeping
    always_comb begin
        state_nxt_s     = state_r;
        slot_nxt_s      = slot_r;
        cnt_nxt_s       = cnt_r;
        drop_seen_nxt_s = drop_seen_r;
        for (int i = 0; i < N_SLOTS; i++) begin
            stock_nxt_s[i] = stock[i];
        end

        case (state_r)
            S_IDLE: begin
                // Refill wins over a simultaneous request; the request is
                // still high next cycle and is honoured then.
                if (bus.refill) begin
                    for (int i = 0; i < N_SLOTS; i++) begin
                        stock_nxt_s[i] = STOCK_LOAD;
                    end
                end else if (bus.req) begin
                    slot_nxt_s = bus.prod;
                    if (prod_valid_s && prod_stocked_s) begin
                        state_nxt_s     = S_RUN;
                        cnt_nxt_s       = CNT_ZERO;
                        drop_seen_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = S_NACK;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end

            S_RUN: begin
                // A fast product can hit the sensor while the motor still turns
                drop_seen_nxt_s = drop_seen_r | bus.drop_sns;
                if (cnt_r == RUN_LAST) begin
                    state_nxt_s = S_DROP;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end

            S_DROP: begin
                if (drop_seen_r || bus.drop_sns) begin
                    state_nxt_s = S_DONE;
                end else if (cnt_r == DROP_LAST) begin
                    state_nxt_s = S_FAULT;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end

            S_DONE: begin
                // Saturating decrement of the vended slot
                for (int i = 0; i < N_SLOTS; i++) begin
                    stock_nxt_s[i] = ((slot_r == 3'(i)) && (stock[i] != STOCK_ZERO)) ?
                                     (stock[i] - STOCK_ONE) : stock[i];
                end
                state_nxt_s = S_WAIT_REL;
            end

            S_NACK: begin
                state_nxt_s = S_WAIT_REL;
            end

            S_WAIT_REL: begin
                // Requester must drop req before another vend can start
                if (!bus.req) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_WAIT_REL;
                end
            end

            S_FAULT: begin
                if (bus.refill) begin
                    for (int i = 0; i < N_SLOTS; i++) begin
                        stock_nxt_s[i] = STOCK_LOAD;
                    end
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_FAULT;
                end
            end

            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Output decode of the next state, loaded into the output flops
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            motor_nxt_s[i] = (state_nxt_s == S_RUN) && (slot_nxt_s == 3'(i));
            empty_nxt_s[i] = (stock_nxt_s[i] == STOCK_ZERO);
        end
    end

    // State, stock and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            slot_r      <= 3'd0;
            cnt_r       <= CNT_ZERO;
            drop_seen_r <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                stock[i] <= STOCK_LOAD;
            end
            motor_r <= {N_SLOTS{1'b0}};
            busy_r  <= 1'b0;
            ack_r   <= 1'b0;
            nack_r  <= 1'b0;
            fault_r <= 1'b0;
            empty_r <= {N_SLOTS{(STOCK_LOAD == STOCK_ZERO)}};
        end else begin
            state_r     <= state_nxt_s;
            slot_r      <= slot_nxt_s;
            cnt_r       <= cnt_nxt_s;
            drop_seen_r <= drop_seen_nxt_s;
            for (int i = 0; i < N_SLOTS; i++) begin
                stock[i] <= stock_nxt_s[i];
            end
            motor_r <= motor_nxt_s;
            busy_r  <= (state_nxt_s != S_IDLE);
            ack_r   <= (state_nxt_s == S_DONE);
            nack_r  <= (state_nxt_s == S_NACK);
            fault_r <= (state_nxt_s == S_FAULT);
            empty_r <= empty_nxt_s;
        end
    end

    assign bus.motor = motor_r;
    assign bus.busy  = busy_r;
    assign bus.ack   = ack_r;
    assign bus.nack  = nack_r;
    assign bus.fault = fault_r;
    assign bus.empty = empty_r;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser (N_SLOTS=6, RUN_CYCLES=4, DROP_TIMEOUT=8,
// STOCK_INIT=2). Each request pushes its expected response (ack or nack) to a
// queue; a negedge monitor pops and compares whenever ack or nack pulses.
module tb_vend_dispenser;

    localparam int NS = 6;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [1:0] exp_q [$];   // 1 = ack, 2 = nack

    vend_dispenser_if #(.N_SLOTS(NS)) bus ();

    vend_dispenser #(
        .N_SLOTS(NS), .RUN_CYCLES(4), .DROP_TIMEOUT(8), .STOCK_W(4), .STOCK_INIT(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stock(input int slot, input logic [3:0] exp);
        chk($sformatf("stock[%0d]", slot), 32'(dut.stock[slot]), 32'(exp));
    endtask

    // One vend attempt. drop_edge = edge (counted from acceptance) at which
    // drop_sns is sampled high; 0 means the sensor never fires.
    // Motor is on after edges 0..3, DROP covers edges 5..12; no drop -> fault after edge 12.
    task automatic vend(input logic [2:0] p, input int drop_edge, input bit exp_ack);
        int         end_e;
        logic [5:0] oh;
        oh = 6'd1 << p;
        if (!exp_ack)            end_e = 12;
        else if (drop_edge <= 4) end_e = 5;
        else                     end_e = drop_edge;
        bus.req      = 1'b1;
        bus.prod     = p;
        bus.drop_sns = 1'b0;
        if (exp_ack) exp_q.push_back(2'd1);
        for (int e = 0; e <= end_e; e++) begin
            cyc(1);
            chk("motor", 32'(bus.motor), 32'((e <= 3) ? oh : 6'd0));
            chk("fault", 32'(bus.fault), 32'(!exp_ack && (e == 12)));
            bus.drop_sns = (e + 1 == drop_edge);
        end
        bus.drop_sns = 1'b0;
        if (exp_ack) chk("ack_pulse", 32'(bus.ack), 32'd1);
        else         chk("busy_fault", 32'(bus.busy), 32'd1);
    endtask

    task automatic release_req();
        bus.req = 1'b0;
        cyc(2);
        chk("busy_rel", 32'(bus.busy), 32'd0);
    endtask

    // Scoreboard: every ack/nack pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        logic [1:0] got;
        logic [1:0] want;
        if (!rst && (bus.ack || bus.nack)) begin
            n_tests++;
            got = bus.ack ? 2'd1 : 2'd2;
            if (exp_q.size() == 0) begin
                assert (1'b0) else begin
                    n_fail++;
                    $error("FAIL sb_extra: got response %0d expected none", got);
                end
            end else begin
                want = exp_q.pop_front();
                assert (got === want) else begin
                    n_fail++;
                    $error("FAIL sb_resp: got %0d expected %0d", got, want);
                end
            end
        end
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.req      = 1'b0;
        bus.prod     = 3'd0;
        bus.drop_sns = 1'b0;
        bus.refill   = 1'b0;
        cyc(2);
        rst = 1'b0;

        // Reset state
        chk("rst_motor", 32'(bus.motor), 32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_ack",   32'(bus.ack),   32'd0);
        chk("rst_nack",  32'(bus.nack),  32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd0);
        for (int i = 0; i < NS; i++) chk_stock(i, 4'd2);

        // 1: normal vend on slot 3, drop seen in DROP
        vend(3'd3, 6, 1'b1);
        chk_stock(3, 4'd2);          // not yet decremented during ack cycle
        cyc(1);
        chk_stock(3, 4'd1);
        bus.req = 1'b0;
        cyc(1);
        chk("t1_busy", 32'(bus.busy), 32'd0);

        // 2: drain slot 5, nack on empty, refill, vend again
        vend(3'd5, 6, 1'b1);
        release_req();
        vend(3'd5, 7, 1'b1);
        release_req();
        chk("t2_empty5", 32'(bus.empty), 32'h20);
        bus.req  = 1'b1;
        bus.prod = 3'd5;
        exp_q.push_back(2'd2);
        cyc(1);
        chk("t2_nack",  32'(bus.nack),  32'd1);
        chk("t2_motor", 32'(bus.motor), 32'd0);
        cyc(1);
        chk("t2_nack_1cyc", 32'(bus.nack), 32'd0);
        chk_stock(5, 4'd0);
        release_req();
        bus.refill = 1'b1;
        cyc(1);
        bus.refill = 1'b0;
        chk("t2_refill_empty", 32'(bus.empty), 32'd0);
        vend(3'd5, 5, 1'b1);
        release_req();

        // 3: no drop -> fault after timeout, req ignored, refill clears
        vend(3'd2, 0, 1'b0);
        chk_stock(2, 4'd2);
        cyc(3);
        chk("t3_fault_sticky", 32'(bus.fault), 32'd1);
        chk("t3_motor_off",    32'(bus.motor), 32'd0);
        bus.req = 1'b0;
        cyc(1);
        bus.refill = 1'b1;
        cyc(1);
        bus.refill = 1'b0;
        chk("t3_fault_clr", 32'(bus.fault), 32'd0);
        chk("t3_idle",      32'(bus.busy),  32'd0);

        // 4: drop only during RUN; req held long after ack
        vend(3'd1, 2, 1'b1);
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            chk("t4_hold_busy", 32'(bus.busy), 32'd1);
        end
        chk_stock(1, 4'd1);
        release_req();

        // 5: out-of-range codes, then refill+req in the same IDLE cycle
        for (int p = 6; p < 8; p++) begin
            bus.req  = 1'b1;
            bus.prod = 3'(p);
            exp_q.push_back(2'd2);
            cyc(1);
            chk("t5_nack",  32'(bus.nack),  32'd1);
            chk("t5_motor", 32'(bus.motor), 32'd0);
            release_req();
        end
        vend(3'd0, 6, 1'b1);
        release_req();
        chk_stock(0, 4'd1);
        bus.req    = 1'b1;
        bus.prod   = 3'd0;
        bus.refill = 1'b1;
        cyc(1);
        bus.refill = 1'b0;
        chk("t5_refill_first_busy",  32'(bus.busy),  32'd0);
        chk("t5_refill_first_motor", 32'(bus.motor), 32'd0);
        chk_stock(0, 4'd2);
        vend(3'd0, 6, 1'b1);
        release_req();

        // 6: reset mid-RUN aborts and reloads stock
        bus.req  = 1'b1;
        bus.prod = 3'd4;
        cyc(1);
        chk("t6_motor_on", 32'(bus.motor), 32'h10);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk("t6_motor_off", 32'(bus.motor), 32'd0);
        chk("t6_busy",      32'(bus.busy),  32'd0);
        for (int i = 0; i < NS; i++) chk_stock(i, 4'd2);
        rst     = 1'b0;
        bus.req = 1'b0;
        cyc(2);
        chk("t6_idle", 32'(bus.busy), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
